// File: rtl/crc_pkg.sv
// Shared definitions for the CRC frame serializer and the CRC engine it feeds:
// default widths, the serializer state encoding and a constant clog2 helper.
package crc_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CRC_WIDTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CRC_WAIT = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

    // Ceiling log2; returns 0 for values <= 1, so callers clamp widths to 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/crc_frame_serializer_if.sv
// Handshake input stream plus the serial link towards the CRC engine.
// master = upstream word source, slave = the serializer.
interface crc_frame_serializer_if
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_VALID;
    logic                  IN_LAST;
    logic                  IN_READY;
    logic                  CRC_CLR;
    logic                  DATA;
    logic                  ACTIVE;
    logic                  BUSY;
    logic                  FRAME_DONE;
    logic                  UNDERRUN;

    modport master (
        output IN_DATA, IN_VALID, IN_LAST,
        input  IN_READY, CRC_CLR, DATA, ACTIVE, BUSY, FRAME_DONE, UNDERRUN
    );

    modport slave (
        input  IN_DATA, IN_VALID, IN_LAST,
        output IN_READY, CRC_CLR, DATA, ACTIVE, BUSY, FRAME_DONE, UNDERRUN
    );
endinterface

// File: rtl/crc_bit_shifter.sv
// Load/shift register with bit counter. Shifts right so bit 0 leaves first;
// a load always wins over a shift so a back-to-back word replaces the
// register on the same edge that would otherwise advance it.
module crc_bit_shifter
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  shift_i,
    output logic                  serial_o,
    output logic                  last_bit_o
);
    localparam int CNT_W = (clog2(DATA_WIDTH) > 0) ? clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

    assign serial_o   = shreg_q[0];
    assign last_bit_o = (bit_cnt_q == CNT_LAST);

    // Next-state: load restarts the count, shift advances it and wraps after the last bit.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load_i) begin
            shreg_d   = load_data_i;
            bit_cnt_d = '0;
        end else if (shift_i) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = last_bit_o ? '0 : bit_cnt_q + 1'b1;
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: rtl/crc_frame_serializer.sv
// Feeds message words bit-serially (LSB first) into the serial CRC engine.
// Each frame: one-cycle engine clear, gapless message bits with ACTIVE high,
// then a CRC shift-out window and a guard gap before the next frame.
// GAP_CYCLES must be at least 1 (FRAME_DONE is decoded in the last gap cycle).
module crc_frame_serializer
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CRC_WIDTH  = DEF_CRC_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input logic                 CLK,
    input logic                 RST,
    crc_frame_serializer_if.slave ser
);
    localparam int WAIT_MAX = (CRC_WIDTH > GAP_CYCLES) ? CRC_WIDTH : GAP_CYCLES;
    localparam int WAIT_W   = (clog2(WAIT_MAX + 1) > 0) ? clog2(WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] CRC_LAST = WAIT_W'(CRC_WIDTH - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              last_flag_q, last_flag_d;
    logic              underrun_q, underrun_d;

    logic in_ready;
    logic xfer;
    logic serial_bit;
    logic last_bit;

    // Ready depends only on state/counters, never on IN_VALID.
    assign in_ready = RST && ((state_q == ST_IDLE) ||
                              (state_q == ST_SHIFT && last_bit && !last_flag_q));
    assign xfer     = ser.IN_VALID && in_ready;

    crc_bit_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .load_i      (xfer),
        .load_data_i (ser.IN_DATA),
        .shift_i     (state_q == ST_SHIFT),
        .serial_o    (serial_bit),
        .last_bit_o  (last_bit)
    );

    // Frame sequencing; an underrun closes the frame as if IN_LAST had been seen.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        last_flag_d = xfer ? ser.IN_LAST : last_flag_q;
        underrun_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (xfer) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit && !xfer) begin
                    state_d    = ST_CRC_WAIT;
                    wait_cnt_d = '0;
                    underrun_d = !last_flag_q;
                end
            end
            ST_CRC_WAIT: begin
                if (wait_cnt_q == CRC_LAST) begin
                    state_d    = ST_GAP;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (wait_cnt_q == GAP_LAST) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Control registers; reset aborts any frame without a completion pulse.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            last_flag_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            last_flag_q <= last_flag_d;
            underrun_q  <= underrun_d;
        end
    end

    assign ser.IN_READY   = in_ready;
    assign ser.CRC_CLR    = (state_q != ST_START);
    assign ser.ACTIVE     = (state_q == ST_SHIFT);
    assign ser.DATA       = (state_q == ST_SHIFT) && serial_bit;
    assign ser.BUSY       = (state_q != ST_IDLE);
    assign ser.FRAME_DONE = (state_q == ST_GAP) && (wait_cnt_q == GAP_LAST);
    assign ser.UNDERRUN   = underrun_q;
endmodule

// File: tb/tb_crc_frame_serializer.sv
// Self-checking bench: directed frames from the test plan plus random frames,
// all compared cycle by cycle against a frame-timeline reference model.
module tb_crc_frame_serializer;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int GW = 1;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    crc_frame_serializer_if #(.DATA_WIDTH(DW)) bus ();

    crc_frame_serializer #(
        .DATA_WIDTH (DW),
        .CRC_WIDTH  (CW),
        .GAP_CYCLES (GW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .ser (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int frame_id = 0;
    logic [7:0] fw [0:7];
    logic [7:0] crc_mon;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {IN_READY, CRC_CLR, DATA, ACTIVE, BUSY, FRAME_DONE, UNDERRUN}
    function automatic logic [6:0] outs();
        return {bus.IN_READY, bus.CRC_CLR, bus.DATA, bus.ACTIVE,
                bus.BUSY, bus.FRAME_DONE, bus.UNDERRUN};
    endfunction

    // Expected outputs in cycle c after the acceptance edge of an n-word frame.
    function automatic logic [6:0] exp_vec(input int c, input int n, input bit ur);
        int s;
        int k;
        s = n * DW;
        if (c <= 0 || c >= 2 + s + CW + GW) return 7'b1100000;
        if (c == 1) return 7'b0000100;
        if (c < 2 + s) begin
            k = c - 2;
            return {((k % DW) == DW - 1) && (((k / DW) < n - 1) || ur),
                    1'b1, fw[k / DW][k % DW], 1'b1, 1'b1, 1'b0, 1'b0};
        end
        if (c < 2 + s + CW) return {5'b01001, 1'b0, ur && (c == 2 + s)};
        return {5'b01001, (c == 1 + s + CW + GW), 1'b0};
    endfunction

    function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    function automatic logic [7:0] crc_frame(input int n);
        logic [7:0] crc;
        crc = 8'h00;
        for (int w = 0; w < n; w++)
            for (int b = 0; b < DW; b++)
                crc = crc_step(crc, fw[w][b]);
        return crc;
    endfunction

    // Stand-in CRC engine driven by the serial link.
    always @(posedge CLK) begin
        if (!RST || !bus.CRC_CLR) crc_mon <= 8'h00;
        else if (bus.ACTIVE)      crc_mon <= crc_step(crc_mon, bus.DATA);
    end

    task automatic idle(input int k);
        bus.IN_VALID = 1'b0;
        repeat (k) begin
            @(negedge CLK);
            chk("idle", 32'(outs()), 32'(7'b1100000));
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
    task automatic run_frame(input int n, input bit ur, input int hold_c,
                             input logic [7:0] hold_w, input bit hold_last);
        int s;
        int t_end;
        int nxt;
        s     = n * DW;
        t_end = 2 + s + CW + GW;
        bus.IN_DATA  = fw[0];
        bus.IN_VALID = 1'b1;
        bus.IN_LAST  = (n == 1) && !ur;
        chk($sformatf("f%0d accept", frame_id), 32'(outs()), 32'(exp_vec(0, n, ur)));
        for (int c = 1; c <= t_end; c++) begin
            @(negedge CLK);
            chk($sformatf("f%0d cyc%0d", frame_id, c), 32'(outs()), 32'(exp_vec(c, n, ur)));
            if (c == t_end - 1)
                chk($sformatf("f%0d crc", frame_id), 32'(crc_mon), 32'(crc_frame(n)));
            if (c <= 1 + s) begin
                nxt = (c == 1) ? 1 : ((c - 2) / DW + 1);
                if (nxt < n) begin
                    bus.IN_DATA  = fw[nxt];
                    bus.IN_VALID = 1'b1;
                    bus.IN_LAST  = (nxt == n - 1) && !ur;
                end else begin
                    bus.IN_VALID = 1'b0;
                end
            end else if (hold_c != 0 && c == hold_c) begin
                bus.IN_DATA  = hold_w;
                bus.IN_VALID = 1'b1;
                bus.IN_LAST  = hold_last;
            end
        end
    endtask

    task automatic reset_mid_shift();
        frame_id     = 6;
        fw[0]        = 8'hC3;
        bus.IN_DATA  = fw[0];
        bus.IN_VALID = 1'b1;
        bus.IN_LAST  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            chk($sformatf("rst_frame cyc%0d", c), 32'(outs()), 32'(exp_vec(c, 1, 1'b0)));
            if (c == 1) bus.IN_VALID = 1'b0;
        end
        RST = 1'b0;
        #1;
        chk("rst_ready_forced", 32'(bus.IN_READY), 32'd0);
        repeat (2) begin
            @(negedge CLK);
            chk("rst_hold", 32'(outs()), 32'(7'b0100000));
        end
        RST = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            chk("after_rst", 32'(outs()), 32'(7'b1100000));
        end
        frame_id = 7;
        fw[0]    = 8'hFF;
        run_frame(1, 1'b0, 0, 8'h00, 1'b0);
    endtask

    initial begin
        bit         have_p;
        int         p_n;
        bit         p_ur;
        logic [7:0] p_w0;

        bus.IN_DATA  = '0;
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        RST          = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_outs", 32'(outs()), 32'(7'b0100000));
        RST = 1'b1;
        @(negedge CLK);
        chk("post_reset_idle", 32'(outs()), 32'(7'b1100000));

        frame_id = 1; fw[0] = 8'hA5;
        run_frame(1, 1'b0, 0, 8'h00, 1'b0);

        frame_id = 2; fw[0] = 8'h01; fw[1] = 8'h80;
        run_frame(2, 1'b0, 0, 8'h00, 1'b0);
        idle(2);

        frame_id = 3; fw[0] = 8'h3C;
        run_frame(1, 1'b1, 0, 8'h00, 1'b0);

        frame_id = 4; fw[0] = 8'h96;
        run_frame(1, 1'b0, 12, 8'h55, 1'b1);
        frame_id = 5; fw[0] = 8'h55;
        run_frame(1, 1'b0, 0, 8'h00, 1'b0);

        reset_mid_shift();

        have_p = 1'b0;
        p_n    = 1;
        p_ur   = 1'b0;
        p_w0   = 8'h00;
        for (int f = 0; f < 30; f++) begin
            int         n;
            bit         ur;
            bit         hold;
            int         hc;
            int         nn;
            bit         nur;
            logic [7:0] nw;
            frame_id = 10 + f;
            if (have_p) begin
                n = p_n; ur = p_ur; fw[0] = p_w0;
            end else begin
                n     = $urandom_range(1, 4);
                ur    = ($urandom_range(0, 4) == 0);
                fw[0] = 8'($urandom);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
            for (int j = 1; j < n; j++) fw[j] = 8'($urandom);
            hold = (f < 29) && ($urandom_range(0, 3) == 0);
            nn   = $urandom_range(1, 4);
            nur  = ($urandom_range(0, 4) == 0);
            nw   = 8'($urandom);
            hc   = hold ? (2 + n * DW + $urandom_range(0, CW + GW - 1)) : 0;
            run_frame(n, ur, hc, nw, (nn == 1) && !nur);
            have_p = hold;
            p_n    = nn;
            p_ur   = nur;
            p_w0   = nw;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/crc_frame_serializer.md
Name: crc_frame_serializer

Overview:
- Upstream feeder for the serial CRC engine. Accepts message bytes over a valid/ready handshake and clears the CRC engine before each frame.
- Shifts each byte out LSB-first on DATA while holding ACTIVE high across the whole frame.
- Then idles ACTIVE low for the CRC shift-out window plus a guard gap before accepting the next frame.

Parameters:
- DATA_WIDTH, 8, bits per input word.
- CRC_WIDTH, 8, length of the CRC engine's shift-out window in cycles.
- GAP_CYCLES, 1, idle cycles after the CRC window before returning to IDLE (minimum 1).

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous, active-low reset.
- IN_DATA  input  DATA_WIDTH  message word.
- IN_VALID  input  1  IN_DATA/IN_LAST valid.
- IN_LAST  input  1  word is the final word of the frame.
- IN_READY  output  1  block can accept a word this cycle.
- CRC_CLR  output  1  active-low clear to the CRC engine, one-cycle pulse.
- DATA  output  1  serial bit to the CRC engine.
- ACTIVE  output  1  high while DATA carries message bits.
- BUSY  output  1  high in any state other than IDLE.
- FRAME_DONE  output  1  one-cycle pulse at the end of a frame.
- UNDERRUN  output  1  one-cycle pulse when a frame is force-closed.

Behaviour:
- Reset (RST=0 at a rising edge): state IDLE, counters 0, shift register 0, last_flag 0.
  - Outputs during reset: IN_READY=0, CRC_CLR=1, DATA=0, ACTIVE=0, BUSY=0, FRAME_DONE=0, UNDERRUN=0.
  - IN_READY is forced 0 while RST=0.
- Reset asserted mid-frame aborts at the next edge. No FRAME_DONE or UNDERRUN pulse is generated.
- Transfer occurs on a rising edge with IN_VALID=1 and IN_READY=1. IN_LAST is captured into last_flag.
- IN_READY=1 in IDLE, or in SHIFT when bit_cnt==DATA_WIDTH-1 and last_flag=0. It is 0 otherwise.
- IDLE: ACTIVE=0, DATA=0. A transfer loads the shift register and moves to START.
- START (1 cycle): CRC_CLR=0, ACTIVE=0. Next state is SHIFT with bit_cnt=0.
- SHIFT: ACTIVE=1, DATA=shreg[0]. Each cycle: shift right, bit_cnt increments.
  - At bit_cnt==DATA_WIDTH-1 with a transfer on the same edge: reload the shift register, bit_cnt=0, stay in SHIFT. ACTIVE stays high with no bubble.
  - At bit_cnt==DATA_WIDTH-1 with last_flag=1: go to CRC_WAIT.
  - At bit_cnt==DATA_WIDTH-1 with last_flag=0 and no transfer (underrun): pulse UNDERRUN in the first CRC_WAIT cycle, then go to CRC_WAIT. The frame is closed as if IN_LAST had been seen.
- CRC_WAIT (CRC_WIDTH cycles): ACTIVE=0, DATA=0, IN_READY=0. Then GAP.
- GAP (GAP_CYCLES cycles): ACTIVE=0. FRAME_DONE=1 in the last GAP cycle. Then IDLE.
- Latency:
  - Acceptance edge to CRC_CLR low: 1 cycle.
  - Acceptance edge to first DATA bit with ACTIVE=1: 2 cycles.
  - Frame of N words: ACTIVE high for N*DATA_WIDTH consecutive cycles.
- IN_VALID held during START, CRC_WAIT or GAP is not accepted. The word must be held until IN_READY=1 in IDLE.
- All outputs are registered or decoded from state only, except IN_READY. IN_READY is decoded from state and counters; there is no combinational path from IN_VALID.
- Counter widths: bit_cnt is clog2(DATA_WIDTH). The wait counter is clog2(max(CRC_WIDTH, GAP_CYCLES)+1). Both reset to 0 on every state entry.

Decomposition:
- Package crc_pkg holds:
  - DATA_WIDTH and CRC_WIDTH defaults, shared with the CRC engine.
  - The state enum IDLE/START/SHIFT/CRC_WAIT/GAP.
  - A clog2 function.
- Sub-module crc_bit_shifter holds the load/shift register plus bit_cnt. It exports serial_out and last_bit.
- The FSM, wait counter and handshake logic stay in crc_frame_serializer.

Test Plan:
- Single word, cycles counted from the acceptance edge: 0xA5 with IN_LAST=1 accepted in IDLE.
  - Cycle 1: CRC_CLR=0.
  - Cycles 2-9: ACTIVE=1, DATA=1,0,1,0,0,1,0,1.
  - Cycles 10-17: ACTIVE=0.
  - Cycle 18: FRAME_DONE=1.
  - Cycle 19: IN_READY=1.
  - Applied to the CRC engine, the CRC output must match the golden value.
- Back-to-back: 0x01 then 0x80 (IN_LAST=1) with IN_VALID held high.
  - Second word accepted at the bit-7 edge.
  - ACTIVE high for 16 consecutive cycles; DATA=1 only in cycles 2 and 17.
  - FRAME_DONE in cycle 26.
- Underrun: 0x3C with IN_LAST=0, then IN_VALID=0 across the byte boundary.
  - ACTIVE falls after 8 bits.
  - UNDERRUN=1 in cycle 10, FRAME_DONE=1 in cycle 18.
- Hold-off: IN_VALID=1 with 0x55 asserted during CRC_WAIT.
  - IN_READY stays 0 until IDLE.
  - The word is accepted in cycle 19 and its CRC_CLR pulse appears in cycle 20.
- Reset mid-SHIFT: RST=0 in cycle 5 of a frame.
  - Next edge: ACTIVE=0, BUSY=0, IN_READY=0.
  - No FRAME_DONE pulse.
  - After RST=1, a new 0xFF frame serializes eight 1s correctly.
